mem_wb_stage_buf: RTL and testbench

Parametrised MEM/WB pipeline stage register. It carries the writeback bundle (write enable, result select, load data, ALU result, destination register, PC+4) from the memory stage to the writeback stage. It adds what the plain stage register lacks: synchronous reset, valid/ready handshake, flush, and an optional 2-entry skid buffer so that in_ready is driven from a flop.

---
 rtl/mem_wb_stage_buf.sv | 177 +++++++++++++++++
 tb/tb_mem_wb_stage_buf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB pipeline stage register with valid/ready handshake, flush and an
// optional two-entry skid buffer that lets in_ready come straight from a flop.
module mem_wb_stage_buf #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int RSRC_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WriteM,
    input  logic [RSRC_W-1:0] ResultSrcM,
    input  logic [XLEN-1:0]   ReadDataM,
    input  logic [XLEN-1:0]   AluResultM,
    input  logic [RD_W-1:0]   RdM,
    input  logic [XLEN-1:0]   PCPlus4M,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WriteW,
    output logic [RSRC_W-1:0] ResultSrcW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   AluResultW,
    output logic [RD_W-1:0]   RdW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [1:0]        occupancy
);

    localparam int PW = 1 + RSRC_W + 3 * XLEN + RD_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [PW-1:0] in_pl_s;
    logic [PW-1:0] main_r;
    logic          out_valid_r;
    logic [1:0]    occ_r;
    logic          in_ready_s;
    logic          accept_s;
    logic          consume_s;
    logic          held_write_s;

    assign in_pl_s   = {WriteM, ResultSrcM, ReadDataM, AluResultM, RdM, PCPlus4M};
    assign accept_s  = in_valid & in_ready_s & ~flush;
    assign consume_s = out_valid_r & out_ready;

    assign {held_write_s, ResultSrcW, ReadDataW, AluResultW, RdW, PCPlus4W} = main_r;

    // A bubble or an x0 destination must never reach the register file.
    assign WriteW    = out_valid_r & held_write_s & (RdW != {RD_W{1'b0}});
    assign out_valid = out_valid_r;
    assign occupancy = occ_r;
    assign in_ready  = in_ready_s;

    generate
        if (SKID == 0) begin : g_single
            logic valid_nxt_s;

            assign in_ready_s = ~out_valid_r | out_ready;

            // Next valid for the single entry; flush wins over a new beat.
            always_comb begin
                valid_nxt_s = out_valid_r;
                if (flush) begin
                    valid_nxt_s = 1'b0;
                end else if (accept_s) begin
                    valid_nxt_s = 1'b1;
                end else if (consume_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end

            // Entry register; payload only moves on an accepted beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    occ_r       <= 2'd0;
                    main_r      <= {PW{1'b0}};
                end else begin
                    out_valid_r <= valid_nxt_s;
                    occ_r       <= {1'b0, valid_nxt_s};
                    if (accept_s) begin
                        main_r <= in_pl_s;
                    end
                end
            end
        end else begin : g_skid
            state_t        state_r;
            state_t        state_hs_s;
            state_t        state_nxt_s;
            logic [PW-1:0] skid_r;
            logic          in_ready_r;
            logic          load_main_s;
            logic          load_skid_s;
            logic          move_s;

            assign in_ready_s  = in_ready_r;
            assign state_nxt_s = flush ? ST_EMPTY : state_hs_s;

            // Handshake-driven transitions and payload steering.
            always_comb begin
                state_hs_s  = state_r;
                load_main_s = 1'b0;
                load_skid_s = 1'b0;
                move_s      = 1'b0;
                case (state_r)
                    ST_EMPTY: begin
                        if (accept_s) begin
                            state_hs_s  = ST_ONE;
                            load_main_s = 1'b1;
                        end else begin
                            state_hs_s = ST_EMPTY;
                        end
                    end
                    ST_ONE: begin
                        if (accept_s && !consume_s) begin
                            state_hs_s  = ST_TWO;
                            load_skid_s = 1'b1;
                        end else if (!accept_s && consume_s) begin
                            state_hs_s = ST_EMPTY;
                        end else if (accept_s && consume_s) begin
                            state_hs_s  = ST_ONE;
                            load_main_s = 1'b1;
                        end else begin
                            state_hs_s = ST_ONE;
                        end
                    end
                    ST_TWO: begin
                        if (consume_s) begin
                            state_hs_s = ST_ONE;
                            move_s     = 1'b1;
                        end else begin
                            state_hs_s = ST_TWO;
                        end
                    end
                    default: begin
                        state_hs_s = ST_EMPTY;
                    end
                endcase
            end

            // State, flag and payload registers; flags derive from next state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    occ_r       <= 2'd0;
                    main_r      <= {PW{1'b0}};
                    skid_r      <= {PW{1'b0}};
                end else begin
                    state_r     <= state_nxt_s;
                    in_ready_r  <= (state_nxt_s != ST_TWO);
                    out_valid_r <= (state_nxt_s != ST_EMPTY);
                    occ_r       <= (state_nxt_s == ST_TWO) ? 2'd2 :
                                   (state_nxt_s == ST_ONE) ? 2'd1 : 2'd0;
                    if (load_main_s) begin
                        main_r <= in_pl_s;
                    end else if (move_s) begin
                        main_r <= skid_r;
                    end
                    if (load_skid_s) begin
                        skid_r <= in_pl_s;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Scoreboard bench for mem_wb_stage_buf: one SKID=1 and one SKID=0 instance,
// directed beats pushed on acceptance, monitors pop and compare on consume.
module tb_mem_wb_stage_buf;

    typedef struct packed {
        logic        w;
        logic [1:0]  rs;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic  iv1 = 1'b0, or1 = 1'b0, fl1 = 1'b0;
    logic  iv0 = 1'b0, or0 = 1'b0, fl0 = 1'b0;
    beat_t b1 = '0, b0 = '0;

    logic        ir1, ov1, ww1, ir0, ov0, ww0;
    logic [1:0]  rsw1, rsw0, occ1, occ0;
    logic [31:0] rdatw1, aluw1, pcw1, rdatw0, aluw0, pcw0;
    logic [4:0]  rdw1, rdw0;

    beat_t q1[$];
    beat_t q0[$];
    int n_vec  = 0;
    int n_fail = 0;

    mem_wb_stage_buf #(.XLEN(32), .RD_W(5), .RSRC_W(2), .SKID(1)) u1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .WriteM(b1.w), .ResultSrcM(b1.rs), .ReadDataM(b1.rdat), .AluResultM(b1.alu),
        .RdM(b1.rd), .PCPlus4M(b1.pc), .out_valid(ov1), .out_ready(or1),
        .WriteW(ww1), .ResultSrcW(rsw1), .ReadDataW(rdatw1), .AluResultW(aluw1),
        .RdW(rdw1), .PCPlus4W(pcw1), .occupancy(occ1)
    );

    mem_wb_stage_buf #(.XLEN(32), .RD_W(5), .RSRC_W(2), .SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .WriteM(b0.w), .ResultSrcM(b0.rs), .ReadDataM(b0.rdat), .AluResultM(b0.alu),
        .RdM(b0.rd), .PCPlus4M(b0.pc), .out_valid(ov0), .out_ready(or0),
        .WriteW(ww0), .ResultSrcW(rsw0), .ReadDataW(rdatw0), .AluResultW(aluw0),
        .RdW(rdw0), .PCPlus4W(pcw0), .occupancy(occ0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic w, input logic [4:0] rd, input logic [31:0] alu);
        beat_t b;
        b.w    = w;
        b.rs   = alu[1:0];
        b.rdat = alu ^ 32'hFFFF_0000;
        b.alu  = alu;
        b.rd   = rd;
        b.pc   = alu + 32'd4;
        return b;
    endfunction

    // Monitors: every consumed beat must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) begin
                chk("skid1_unexpected_beat", {96'd0, aluw1}, 128'd0);
            end else begin
                beat_t e;
                e = q1.pop_front();
                chk("skid1_payload", {rsw1, rdatw1, aluw1, rdw1, pcw1},
                    {e.rs, e.rdat, e.alu, e.rd, e.pc});
                chk("skid1_WriteW", ww1, e.w && (e.rd != 5'd0));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            if (q0.size() == 0) begin
                chk("skid0_unexpected_beat", {96'd0, aluw0}, 128'd0);
            end else begin
                beat_t e;
                e = q0.pop_front();
                chk("skid0_payload", {rsw0, rdatw0, aluw0, rdw0, pcw0},
                    {e.rs, e.rdat, e.alu, e.rd, e.pc});
                chk("skid0_WriteW", ww0, e.w && (e.rd != 5'd0));
            end
        end
    end

    // Offer one beat until accepted; push the expectation on acceptance.
    task automatic send(input int d, input beat_t b, input int exp_occ);
        logic rdy;
        bit   done;
        done = 1'b0;
        if (d == 1) begin b1 = b; iv1 = 1'b1; end
        else        begin b0 = b; iv0 = 1'b1; end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && exp_occ >= 0)
                chk("occ_before_send", (d == 1) ? occ1 : occ0, exp_occ[1:0]);
            rdy = (d == 1) ? (ir1 & ~fl1) : (ir0 & ~fl0);
            @(posedge clk);
            if (rdy) begin
                if (d == 1) q1.push_back(b);
                else        q0.push_back(b);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 128'd0, 128'd1);
        #1;
        if (d == 1) iv1 = 1'b0;
        else        iv0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live beat on the inputs.
        b1 = mk(1'b1, 5'd5, 32'h1234_5678);
        b0 = b1;
        iv1 = 1'b1; iv0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid1", ov1, 1'b0);
        chk("rst_outputs1", {ww1, rsw1, rdatw1, aluw1, rdw1, pcw1}, 128'd0);
        chk("rst_occ1", occ1, 2'd0);
        chk("rst_out_valid0", ov0, 1'b0);
        chk("rst_outputs0", {ww0, rsw0, rdatw0, aluw0, rdw0, pcw0}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready1", ir1, 1'b1);
        chk("post_rst_in_ready0", ir0, 1'b1);
        idle(1);

        // Streaming with out_ready high.
        or1 = 1'b1;
        send(1, mk(1'b1, 5'd3, 32'd1), 0);
        send(1, mk(1'b0, 5'd4, 32'd2), 1);
        send(1, mk(1'b1, 5'd7, 32'd3), 1);
        @(negedge clk);
        chk("stream_occ", occ1, 2'd1);
        idle(2);

        // Stall fills main and skid, then drains in order.
        or1 = 1'b0;
        send(1, mk(1'b1, 5'd10, 32'hA0A0_0001), 0);
        send(1, mk(1'b1, 5'd11, 32'hB0B0_0002), 1);
        @(negedge clk);
        chk("stall_occ_full", occ1, 2'd2);
        chk("stall_in_ready_full", ir1, 1'b0);
        @(posedge clk); #1;
        or1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("drain_in_ready", ir1, 1'b1);
        chk("drain_occ", occ1, 2'd1);
        idle(2);

        // x0 destination never writes.
        send(1, mk(1'b1, 5'd0, 32'hDEAD_BEEF), 0);
        @(negedge clk);
        chk("x0_out_valid", ov1, 1'b1);
        chk("x0_WriteW", ww1, 1'b0);
        chk("x0_alu", aluw1, 32'hDEAD_BEEF);
        idle(2);

        // Flush with a full buffer, a same-cycle beat and a same-cycle consume.
        or1 = 1'b0;
        send(1, mk(1'b1, 5'd12, 32'h0000_D00D), 0);
        send(1, mk(1'b1, 5'd13, 32'h0000_E00E), 1);
        b1 = mk(1'b1, 5'd14, 32'h0000_C00C);
        iv1 = 1'b1; fl1 = 1'b1; or1 = 1'b1;
        @(negedge clk);
        chk("flush_occ_before", occ1, 2'd2);
        @(posedge clk); #1;
        fl1 = 1'b0; iv1 = 1'b0;
        q1.delete();
        @(negedge clk);
        chk("flush_out_valid", ov1, 1'b0);
        chk("flush_occ", occ1, 2'd0);
        idle(3);

        // Flush with one entry held and in_ready high discards the input beat.
        or1 = 1'b0;
        send(1, mk(1'b1, 5'd15, 32'h0000_0F0F), 0);
        b1 = mk(1'b1, 5'd16, 32'h0000_1111);
        iv1 = 1'b1; fl1 = 1'b1;
        @(posedge clk); #1;
        fl1 = 1'b0; iv1 = 1'b0;
        q1.delete();
        @(negedge clk);
        chk("flush1_out_valid", ov1, 1'b0);
        chk("flush1_occ", occ1, 2'd0);
        or1 = 1'b1;
        idle(3);
        send(1, mk(1'b1, 5'd17, 32'h0000_2222), 0);
        idle(2);

        // Single-entry build: combinational in_ready and one-cycle replace.
        or0 = 1'b0;
        send(0, mk(1'b1, 5'd20, 32'h5555_0001), 0);
        @(negedge clk);
        chk("s0_in_ready_stall", ir0, 1'b0);
        chk("s0_occ_stall", occ0, 2'd1);
        @(posedge clk); #1;
        or0 = 1'b1;
        b0 = mk(1'b0, 5'd21, 32'h6666_0002);
        iv0 = 1'b1;
        #1;
        chk("s0_in_ready_comb", ir0, 1'b1);
        send(0, mk(1'b0, 5'd21, 32'h6666_0002), 1);
        @(negedge clk);
        chk("s0_occ_replace", occ0, 2'd1);
        idle(3);

        chk("q1_drained", q1.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
